// File: rtl/ahb_lite_master_arbiter_pkg.sv
// Shared AHB-Lite codes, FSM state encodings and request helpers for the
// two-requester AHB-Lite master.
package ahb_lite_master_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        lock;
  } cmd_t;

  // Requests that this 32-bit master cannot legally put on the bus.
  function automatic logic is_unaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && addr_lo[0]) ||
           ((size == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_lite_rr_arbiter.sv
// Two-way round-robin grant with a sticky lock owner; grants only while
// i_en is high (master FSM idle).
module ahb_lite_rr_arbiter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  input  logic [1:0] i_lock,
  output logic [1:0] o_grant,
  output logic       o_grant_vld,
  output logic       o_grant_idx
);

  logic r_ptr;
  logic r_owner;
  logic r_owner_vld;

  logic w_owner_active;
  logic w_idx;
  logic w_vld;

  // The owner keeps exclusivity only while it still holds its lock request.
  always_comb begin
    w_owner_active = r_owner_vld && i_lock[r_owner];
    w_idx          = r_ptr;
    w_vld          = 1'b0;
    if (w_owner_active) begin
      w_idx = r_owner;
      w_vld = i_valid[r_owner];
    end else if (&i_valid) begin
      w_idx = r_ptr;
      w_vld = 1'b1;
    end else if (i_valid[0]) begin
      w_idx = 1'b0;
      w_vld = 1'b1;
    end else if (i_valid[1]) begin
      w_idx = 1'b1;
      w_vld = 1'b1;
    end
  end

  assign o_grant_vld = w_vld && i_en;
  assign o_grant_idx = w_idx;
  assign o_grant     = o_grant_vld ? (w_idx ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_owner_vld <= 1'b0;
    end else if (i_en) begin
      if (!w_owner_active) r_owner_vld <= 1'b0;
      if (o_grant_vld) begin
        r_ptr <= ~w_idx;
        if (i_lock[w_idx]) begin
          r_owner     <= w_idx;
          r_owner_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// AHB-Lite master shared by two requesters: single non-overlapped transfers,
// round-robin with lock, local rejection of misaligned/oversized requests.
module ahb_lite_master_arbiter
  import ahb_lite_master_arbiter_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_lock,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [5:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_accept,
  output logic [1:0]  rsp_done,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  logic [1:0]  r_state;
  cmd_t        r_cmd;
  logic        r_idx;
  logic [1:0]  r_rsp_done;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [1:0]  w_grant;
  logic        w_grant_vld;
  logic        w_grant_idx;
  cmd_t        w_sel;
  logic        w_bad;

  ahb_lite_rr_arbiter u_arb (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_en        (r_state == ST_IDLE),
    .i_valid     (req_valid),
    .i_lock      (req_lock),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld),
    .o_grant_idx (w_grant_idx)
  );

  always_comb begin
    w_sel.addr  = w_grant_idx ? req_addr[63:32]  : req_addr[31:0];
    w_sel.write = w_grant_idx ? req_write[1]     : req_write[0];
    w_sel.size  = w_grant_idx ? req_size[5:3]    : req_size[2:0];
    w_sel.wdata = w_grant_idx ? req_wdata[63:32] : req_wdata[31:0];
    w_sel.lock  = w_grant_idx ? req_lock[1]      : req_lock[0];
    w_bad       = is_unaligned(w_sel.size, w_sel.addr[1:0]);
  end

  assign req_accept = w_grant;
  assign rsp_done   = r_rsp_done;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;

  // Bus fields come straight from the captured command so they hold in IDLE.
  assign HADDR     = r_cmd.addr;
  assign HWRITE    = r_cmd.write;
  assign HSIZE     = r_cmd.size;
  assign HWDATA    = r_cmd.wdata;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HMASTLOCK = (r_state != ST_IDLE) && r_cmd.lock;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_idx       <= 1'b0;
      r_rsp_done  <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_done  <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            if (w_bad) begin
              // Rejected locally: answer with an error, never touch the bus.
              r_rsp_done <= w_grant;
              r_rsp_err  <= 1'b1;
            end else begin
              r_cmd   <= w_sel;
              r_idx   <= w_grant_idx;
              r_state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (HREADY) begin
            r_state     <= ST_IDLE;
            r_rsp_done  <= r_idx ? 2'b10 : 2'b01;
            r_rsp_err   <= HRESP;
            r_rsp_rdata <= r_cmd.write ? 32'h0 : HRDATA;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench for ahb_lite_master_arbiter: a transaction-level model checked
// every cycle plus hand-computed expectations for each scenario.
module tb_ahb_lite_master_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_lock;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [5:0]  req_size;
  logic [63:0] req_wdata;
  logic [1:0]  req_accept;
  logic [1:0]  rsp_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  ahb_lite_master_arbiter #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_lock(req_lock), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_accept(req_accept), .rsp_done(rsp_done), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;
  int grant_log[$];
  int lk_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_bad(input logic [2:0] sz, input logic [31:0] a);
    if (sz > 3'd2) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  // Transaction-level model: phase counts bus cycles of the current transfer.
  bit          m_known = 0;
  int          m_phase, m_who, m_owner, m_last;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size;
  logic        m_write, m_lock, m_err;
  logic [1:0]  m_done;

  always @(negedge HCLK) begin
    int w;
    logic [1:0] e_acc;
    w = -1;
    if (m_known && m_phase == 0) begin
      if (m_owner >= 0 && req_lock[m_owner]) begin
        if (req_valid[m_owner]) w = m_owner;
      end else if (req_valid == 2'b11) w = (m_last == 0) ? 1 : 0;
      else if (req_valid[0]) w = 0;
      else if (req_valid[1]) w = 1;
    end
    e_acc = (w < 0) ? 2'b00 : (2'b01 << w);

    if (m_known) begin
      chk("req_accept", req_accept, e_acc);
      chk("HTRANS", HTRANS, (m_phase == 1) ? 2'b10 : 2'b00);
      chk("HMASTLOCK", HMASTLOCK, (m_phase != 0) && m_lock);
      chk("HADDR", HADDR, m_addr);
      chk("HWRITE", HWRITE, m_write);
      chk("HSIZE", HSIZE, m_size);
      chk("HWDATA", HWDATA, m_wdata);
      chk("HBURST", HBURST, 3'b000);
      chk("HPROT", HPROT, 4'b0011);
      chk("rsp_done", rsp_done, m_done);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (req_accept[0]) grant_log.push_back(0);
      if (req_accept[1]) grant_log.push_back(1);
      if (HTRANS == 2'b10 && HMASTLOCK) lk_cnt++;
    end

    if (HRESET) begin
      m_known = 1; m_phase = 0; m_who = 0; m_owner = -1; m_last = -1;
      m_addr = 0; m_wdata = 0; m_size = 0; m_write = 0; m_lock = 0;
      m_done = 0; m_err = 0; m_rdata = 0;
    end else if (m_known) begin
      m_done = 0; m_err = 0; m_rdata = 0;
      if (m_phase == 0) begin
        if (m_owner >= 0 && !req_lock[m_owner]) m_owner = -1;
        if (w >= 0) begin
          m_last = w;
          if (req_lock[w]) m_owner = w;
          if (tb_bad(req_size[w*3 +: 3], req_addr[w*32 +: 32])) begin
            m_done[w] = 1'b1;
            m_err = 1'b1;
          end else begin
            m_addr  = req_addr[w*32 +: 32];
            m_wdata = req_wdata[w*32 +: 32];
            m_size  = req_size[w*3 +: 3];
            m_write = req_write[w];
            m_lock  = req_lock[w];
            m_who   = w;
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (HREADY) m_phase = 2;
      end else begin
        if (HREADY) begin
          m_phase = 0;
          m_done[m_who] = 1'b1;
          m_err   = HRESP;
          m_rdata = m_write ? 32'h0 : HRDATA;
        end
      end
    end
  end

  task automatic step(); @(posedge HCLK); #1; endtask
  task automatic mid();  @(negedge HCLK); #1; endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic wr,
                         input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    req_valid[i] = v;
    req_lock[i]  = lk;
    req_write[i] = wr;
    req_addr[i*32 +: 32]  = a;
    req_size[i*3 +: 3]    = sz;
    req_wdata[i*32 +: 32] = wd;
  endtask

  task automatic do_reset();
    step();
    HRESET = 1'b1; req_valid = 0; req_lock = 0; HREADY = 1'b1; HRESP = 1'b0;
    step();
    HRESET = 1'b0;
    grant_log.delete();
    lk_cnt = 0;
  endtask

  task automatic wait_accept(input int n, input int maxc);
    for (int k = 0; k < maxc; k++) begin
      mid();
      if (grant_log.size() >= n) break;
      step();
    end
    chk("accept_count", grant_log.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] bad_addr [3] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
  logic [2:0]  bad_size [3] = '{3'd1, 3'd2, 3'd3};

  initial begin
    HRESET = 1'b1; req_valid = 0; req_lock = 0; req_write = 0; req_addr = 0;
    req_size = 0; req_wdata = 0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    repeat (3) step();
    mid();
    chk("rst_HTRANS", HTRANS, 2'b00);
    chk("rst_HPROT", HPROT, 4'b0011);
    chk("rst_HADDR", HADDR, 32'h0);
    chk("rst_rsp_done", rsp_done, 2'b00);
    chk("rst_HMASTLOCK", HMASTLOCK, 1'b0);

    // Single write, zero wait states
    step(); HRESET = 1'b0; set_req(0, 1, 0, 1, 32'h4, 3'd2, 32'hAA);
    mid();  chk("sw_accept", req_accept, 2'b01);
    step(); req_valid = 0;
    mid();  chk("sw_nonseq", HTRANS, 2'b10); chk("sw_haddr", HADDR, 32'h4);
    step();
    mid();  chk("sw_data_htrans", HTRANS, 2'b00); chk("sw_hwdata", HWDATA, 32'hAA);
    step();
    mid();  chk("sw_done", rsp_done, 2'b01); chk("sw_err", rsp_err, 1'b0);

    // Simultaneous requests alternate 0,1,0,1
    do_reset();
    set_req(0, 1, 0, 1, 32'h100, 3'd2, 32'h1);
    set_req(1, 1, 0, 0, 32'h200, 3'd2, 32'h2);
    HRDATA = 32'hCAFE_0001;
    wait_accept(4, 40);
    step(); req_valid = 0;
    if (grant_log.size() >= 4) begin
      chk("rr_g0", grant_log[0], 0); chk("rr_g1", grant_log[1], 1);
      chk("rr_g2", grant_log[2], 0); chk("rr_g3", grant_log[3], 1);
    end
    repeat (4) begin mid(); step(); end

    // Lock: requester 1 keeps the bus for two transfers
    do_reset();
    set_req(1, 1, 1, 0, 32'h300, 3'd2, 32'h0);
    wait_accept(1, 10);
    step(); set_req(0, 1, 0, 1, 32'h400, 3'd2, 32'h44);
    wait_accept(2, 20);
    step(); set_req(1, 0, 0, 0, 32'h300, 3'd2, 32'h0);
    wait_accept(3, 20);
    if (grant_log.size() >= 3) begin
      chk("lk_g0", grant_log[0], 1); chk("lk_g1", grant_log[1], 1);
      chk("lk_g2", grant_log[2], 0);
    end
    chk("lk_locked_nonseq", lk_cnt, 2);
    step(); req_valid = 0;
    repeat (4) begin mid(); step(); end

    // Wait states on a byte read
    do_reset();
    set_req(0, 1, 0, 0, 32'h1000_0011, 3'd0, 32'h0); HREADY = 1'b0;
    mid();  chk("ws_accept", req_accept, 2'b01);
    step(); req_valid = 0;
    mid();  chk("ws_nonseq0", HTRANS, 2'b10); chk("ws_haddr", HADDR, 32'h1000_0011);
            chk("ws_hsize", HSIZE, 3'd0);
    step();
    mid();  chk("ws_nonseq1", HTRANS, 2'b10);
    step(); HREADY = 1'b1;
    mid();  chk("ws_nonseq2", HTRANS, 2'b10);
    step(); HRDATA = 32'h5A5A_1234;
    mid();  chk("ws_data", HTRANS, 2'b00); chk("ws_not_done", rsp_done, 2'b00);
    step();
    mid();  chk("ws_done", rsp_done, 2'b01); chk("ws_rdata", rsp_rdata, 32'h5A5A_1234);
            chk("ws_err", rsp_err, 1'b0);

    // Two-cycle ERROR response
    step(); set_req(0, 1, 0, 1, 32'h20, 3'd2, 32'h11);
    mid();  chk("er_accept", req_accept, 2'b01);
    step(); req_valid = 0;
    mid();  chk("er_nonseq", HTRANS, 2'b10);
    step(); HREADY = 1'b0; HRESP = 1'b1;
    mid();  chk("er_hwdata", HWDATA, 32'h11);
    step(); HREADY = 1'b1;
    mid();  chk("er_not_done", rsp_done, 2'b00);
    step(); HRESP = 1'b0;
    mid();  chk("er_done", rsp_done, 2'b01); chk("er_err", rsp_err, 1'b1);
            chk("er_rdata", rsp_rdata, 32'h0);

    // Misaligned / oversized requests never reach the bus
    for (int k = 0; k < 3; k++) begin
      step(); set_req(0, 1, 0, 1, bad_addr[k], bad_size[k], 32'hBAD);
      mid();  chk("ma_accept", req_accept, 2'b01); chk("ma_idle0", HTRANS, 2'b00);
      step(); req_valid = 0;
      mid();  chk("ma_idle1", HTRANS, 2'b00); chk("ma_done", rsp_done, 2'b01);
              chk("ma_err", rsp_err, 1'b1); chk("ma_haddr_held", HADDR, 32'h20);
    end

    // Reset while in the data phase abandons the transfer
    step(); set_req(0, 1, 0, 1, 32'h40, 3'd2, 32'h77);
    mid();  chk("rm_accept", req_accept, 2'b01);
    step(); req_valid = 0;
    mid();  chk("rm_nonseq", HTRANS, 2'b10);
    step(); HRESET = 1'b1;
    mid();  chk("rm_data", HTRANS, 2'b00);
    step(); HRESET = 1'b0;
    mid();  chk("rm_htrans", HTRANS, 2'b00); chk("rm_no_done0", rsp_done, 2'b00);
            chk("rm_haddr", HADDR, 32'h0);
    step();
    mid();  chk("rm_no_done1", rsp_done, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_arbiter.md
AHB_LITE_MASTER_ARBITER -- requirements
Module: ahb_lite_master_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter HPROT_VAL, default 4'b0011, is the constant driven on HPROT.
REQ-003 HCLK  in  1  bus clock; all state changes on rising edge.
REQ-004 HRESET  in  1  synchronous active-high reset.
REQ-005 The requester ports SHALL be as follows; requester i occupies bit i, or bits 32i+31:32i, or bits 3i+2:3i:
- req_valid  in  2  per-requester transfer request.
- req_lock  in  2  per-requester lock request.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  64  two 32-bit addresses.
- req_size  in  6  two 3-bit HSIZE codes.
- req_wdata  in  64  two 32-bit write data words.
- req_accept  out  2  one-cycle pulse: request captured.
- rsp_done  out  2  one-cycle pulse: transfer finished.
- rsp_err  out  1  error flag, valid with rsp_done.
- rsp_rdata  out  32  read data, valid with rsp_done.
REQ-006 The AHB-Lite master ports SHALL be as follows:
- HADDR  out  32  transfer address.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  burst type.
- HPROT  out  4  protection control.
- HTRANS  out  2  transfer type.
- HMASTLOCK  out  1  locked transfer.
- HWDATA  out  32  write data.
- HREADY  in  1  transfer ready.
- HRESP  in  1  transfer response.
- HRDATA  in  32  read data.

Function
REQ-007 The FSM SHALL have three states (IDLE, ADDR, DATA); it performs single, non-overlapped transfers.
REQ-008 In IDLE with any req_valid, the block SHALL grant one requester, pulse req_accept[i] combinationally in that cycle, capture addr/write/size/wdata/lock, and go to ADDR.
REQ-009 Arbitration SHALL be round-robin. When both requesters are valid, the winner is the one not granted last; the pointer after reset favours requester 0.
REQ-010 While a lock owner exists, only the owner SHALL be granted, even if it is idle. The owner is set when a granted requester has req_lock=1, and is cleared when its req_lock=0 is sampled in IDLE.
REQ-011 In ADDR, the block SHALL drive:
- HTRANS=NONSEQ (2'b10) and HBURST=SINGLE (3'b000).
- HADDR/HWRITE/HSIZE from the captured values.
- HMASTLOCK equal to the captured lock.
ADDR advances to DATA on HREADY=1 and holds otherwise.
REQ-012 In DATA, HTRANS SHALL be IDLE (2'b00) and HWDATA SHALL be the captured wdata. HMASTLOCK SHALL stay 1 while an owner exists.
REQ-013 In DATA, when HREADY=1 the FSM SHALL return to IDLE. The next cycle carries:
- rsp_done[i]=1
- rsp_err=HRESP
- rsp_rdata = HRDATA for reads, 0 for writes
REQ-014 With zero wait states, the latency SHALL be: accept at cycle 0, ADDR at cycle 1, DATA at cycle 2, rsp_done at cycle 3. The next accept is possible at cycle 3.
REQ-015 A request that is misaligned or oversized SHALL issue no bus transfer; HTRANS stays IDLE. The block pulses req_accept, then rsp_done with rsp_err=1 one cycle later. The cases are:
- halfword with addr[0]=1
- word with addr[1:0]≠0
- size>3'b010
REQ-016 A two-cycle ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) SHALL complete on the second cycle with rsp_err=1.
REQ-017 HADDR/HWRITE/HSIZE/HWDATA SHALL hold their last value in IDLE.

Reset
REQ-018 On HRESET=1 at a clock edge, the FSM SHALL go to IDLE and clear the lock owner and RR pointer. All outputs go to 0, except HPROT=HPROT_VAL. Any transfer in flight is abandoned with no rsp_done.

Structure
REQ-019 The HTRANS, HSIZE and HBURST codes and the FSM state encodings SHALL live in the shared AHB-Lite defines header.
REQ-020 The 2-way round-robin/lock grant logic SHALL be a sub-module, ahb_lite_rr_arbiter.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- **Single write:** req0 write 0x00000004, 0xAA, word, HREADY=1 → HTRANS=NONSEQ at cycle 1, HWDATA=0xAA at cycle 2, rsp_done[0] at cycle 3, rsp_err=0.
- **Simultaneous requests:** both valid in IDLE after reset → req0 granted first, req1 next; repeated three times → grants alternate 0,1,0,1.
- **Lock:** req1 lock=1 for two transfers while req0 is valid → both req1 transfers run with HMASTLOCK=1 before req0 is accepted.
- **Wait states and error:** read 0x10000011 byte with HREADY low two cycles → rsp_done delayed two cycles with rsp_rdata=HRDATA. Two-cycle ERROR response → rsp_err=1.
- **Misaligned:** halfword at 0x00000001 → no NONSEQ, rsp_err=1 one cycle after accept.
- **Reset mid-transfer:** HRESET asserted in DATA → IDLE next edge, HTRANS=0, no rsp_done.
